// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
//   uart_state_t : serialiser FSM states
//   REG_*        : register offsets within the block's address window
//   ST_*         : bit positions inside the STATUS register
//   eff_div()    : maps a programmed divider to the one actually used (0 -> 1)
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   localparam logic [3:0] REG_TXDATA  = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h4;
   localparam logic [3:0] REG_BAUDDIV = 4'h8;

   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_BUSY  = 2;
   localparam int ST_OVF   = 3;

   // A divider of zero would make a bit last no time at all; run it as 1.
   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, reset : clock, synchronous active-high reset (pointers and count)
//   push, din  : write request and data; ignored when full unless popping too
//   pop, dout  : read request and head-of-queue data (valid while !empty)
//   full/empty : count == DEPTH / count == 0
//   count      : number of stored entries, $clog2(DEPTH)+1 bits
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem[rd_ptr_q];

   // A full FIFO can still take a byte when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are AW bits wide, so DEPTH being a power of 2 makes them wrap for free.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter.
//   clk, reset            : clock, synchronous active-high reset
//   read_addr/enable/data : cpu register read port, read_data combinational
//   write_addr/enable/
//   write_data/strb       : cpu register write port with byte enables
//   tx                    : serial output, idle high
// Registers: TXDATA (push byte), STATUS (flags, W1C overflow), BAUDDIV (clk per bit).
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] read_addr,
   input  logic        read_enable,
   output logic [31:0] read_data,
   input  logic [31:0] write_addr,
   input  logic        write_enable,
   input  logic [31:0] write_data,
   input  logic [3:0]  write_strb,
   output logic        tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   // Offsets are computed with a full subtraction so an address below BASE_ADDR
   // wraps to a huge offset and falls outside the window.
   logic [31:0] rd_off, wr_off;
   logic        rd_hit, wr_hit;
   logic [3:0]  rd_reg, wr_reg;

   assign rd_off = read_addr - BASE_ADDR;
   assign wr_off = write_addr - BASE_ADDR;
   assign rd_hit = (rd_off < 32'hC);
   assign wr_hit = (wr_off < 32'hC);
   assign rd_reg = {rd_off[3:2], 2'b00};
   assign wr_reg = {wr_off[3:2], 2'b00};

   logic          push_req;
   logic          fifo_pop;
   logic [7:0]    fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   assign push_req = write_enable && wr_hit && (wr_reg == REG_TXDATA) && write_strb[0];

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_req),
      .pop   (fifo_pop),
      .din   (write_data[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   uart_state_t state_q, state_d;
   logic        tx_q, tx_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [15:0] div_q, div_d;
   logic [15:0] bauddiv_q, bauddiv_d;
   logic        overflow_q, overflow_d;
   logic        bit_end;

   assign tx      = tx_q;
   assign bit_end = (cnt_q == div_q - 16'd1);

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shreg_d    = shreg_q;
      div_d      = div_q;
      bauddiv_d  = bauddiv_q;
      overflow_d = overflow_q;
      fifo_pop   = 1'b0;

      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shreg_d  = fifo_dout;
               tx_d     = 1'b0;
               cnt_d    = '0;
               div_d    = eff_div(bauddiv_q);
               state_d  = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = shreg_q[0];
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = shreg_q >> 1;
                  tx_d    = shreg_q[1];
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               // Chain the next frame straight out of the stop bit with no idle gap.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shreg_d  = fifo_dout;
                  tx_d     = 1'b0;
                  div_d    = eff_div(bauddiv_q);
                  state_d  = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (write_enable && wr_hit && (wr_reg == REG_BAUDDIV)) begin
         if (write_strb[0]) bauddiv_d[7:0]  = write_data[7:0];
         if (write_strb[1]) bauddiv_d[15:8] = write_data[15:8];
      end

      // Clear first so a byte dropped in the same cycle still leaves overflow set.
      if (write_enable && wr_hit && (wr_reg == REG_STATUS) && write_strb[0] && write_data[ST_OVF])
         overflow_d = 1'b0;
      if (push_req && fifo_full && !fifo_pop)
         overflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_q       <= 1'b1;
         cnt_q      <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         div_q      <= 16'd1;
         bauddiv_q  <= DEFAULT_DIV;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         shreg_q    <= shreg_d;
         div_q      <= div_d;
         bauddiv_q  <= bauddiv_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      read_data = '0;
      if (read_enable && rd_hit) begin
         unique case (rd_reg)
            REG_STATUS: begin
               read_data[ST_FULL]  = fifo_full;
               read_data[ST_EMPTY] = fifo_empty;
               read_data[ST_BUSY]  = (state_q != IDLE);
               read_data[ST_OVF]   = overflow_q;
            end
            REG_BAUDDIV: read_data[15:0] = bauddiv_q;
            default:     read_data = '0;
         endcase
      end
   end

   // Upper data bytes, upper strobes and the exact fill level have no use here.
   logic unused_bits;
   assign unused_bits = ^{write_data[31:16], write_strb[3:2], fifo_count};

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: stimulus pushes expected frames into a
// scoreboard queue, an independent line monitor decodes tx and compares.
module tb_uart_tx_mmio;
   import uart_pkg::*;

   localparam logic [31:0] BASE  = 32'h1000_0000;
   localparam int          DEPTH = 8;
   localparam logic [15:0] DDIV  = 16'd868;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] read_addr = '0;
   logic        read_enable = 1'b0;
   logic [31:0] read_data;
   logic [31:0] write_addr = '0;
   logic        write_enable = 1'b0;
   logic [31:0] write_data = '0;
   logic [3:0]  write_strb = '0;
   logic        tx;

   uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DDIV)) dut (
      .clk          (clk),
      .reset        (reset),
      .read_addr    (read_addr),
      .read_enable  (read_enable),
      .read_data    (read_data),
      .write_addr   (write_addr),
      .write_enable (write_enable),
      .write_data   (write_data),
      .write_strb   (write_strb),
      .tx           (tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [7:0] data;
      int         div;
      bit         valid;
   } frame_t;

   frame_t sb_q[$];
   int     start_cyc[$];
   int     n_checks = 0;
   int     n_errors = 0;
   int     frames_seen = 0;
   int     model_div = 868;

   function automatic int eff(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- line monitor ----------------
   bit     mon_active = 1'b0;
   int     mon_j = 0;
   frame_t mon_exp;

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_active = 1'b0;
            continue;
         end
         if (!mon_active && tx === 1'b0) begin
            if (sb_q.size() == 0) begin
               check("unexpected_frame", 32'd1, 32'd0);
               mon_exp = '{8'h00, eff(model_div), 1'b0};
            end else begin
               mon_exp = sb_q.pop_front();
            end
            start_cyc.push_back(cyc);
            mon_active = 1'b1;
            mon_j = 0;
         end
         if (mon_active) begin
            int d;
            int k;
            d = mon_exp.div;
            k = mon_j / d;
            if (mon_j % d == d / 2) begin
               if (k == 0)
                  check("start_bit", {31'd0, tx}, 32'd0);
               else if (k <= 8 && mon_exp.valid)
                  check("data_bit", {31'd0, tx}, {31'd0, mon_exp.data[k-1]});
               else if (k == 9)
                  check("stop_bit", {31'd0, tx}, 32'd1);
            end
            if (mon_j == d - 1 && d - 1 != d / 2)
               check("start_bit_end", {31'd0, tx}, 32'd0);
            if (mon_j == 10 * d - 1 && 10 * d - 1 != 9 * d + d / 2)
               check("stop_bit_end", {31'd0, tx}, 32'd1);
            mon_j++;
            if (mon_j == 10 * d) begin
               mon_active = 1'b0;
               frames_seen++;
            end
         end
      end
   end

   // ---------------- bus tasks (called at posedge + 1) ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      write_addr   = addr;
      write_data   = data;
      write_strb   = strb;
      write_enable = 1'b1;
      @(posedge clk);
      #1;
      write_enable = 1'b0;
      write_strb   = '0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      read_addr   = addr;
      read_enable = 1'b1;
      #1;
      data = read_data;
      read_enable = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      logic [31:0] v;
      bus_read(addr, v);
      check(name, v, exp);
   endtask

   // Push a byte; exp_div is the divider the frame must use when it starts.
   task automatic push(input logic [7:0] b, input int exp_div);
      bus_write(BASE, {$urandom(), b} >> 0 & 32'hFFFF_FF00 | {24'd0, b}, 4'b0001 | 4'($urandom_range(0, 7) << 1));
      sb_q.push_back('{b, exp_div, 1'b1});
   endtask

   task automatic set_div(input int v);
      bus_write(BASE + 32'h8, {16'($urandom()), 16'(v)}, 4'b0011);
      model_div = v;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k = 0;
      while ((sb_q.size() != 0 || mon_active) && k < budget) begin
         tick(1);
         k++;
      end
      check(name, {31'd0, (k >= budget)}, 32'd0);
      tick(2);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int base_idx;
      int f0;
      reset = 1'b1;
      tick(3);
      reset = 1'b0;

      // 1. reset state and read decode
      read_check("reset_status", BASE + 32'h4, 32'h2);
      check("reset_tx", {31'd0, tx}, 32'd1);
      read_check("reset_bauddiv", BASE + 32'h8, {16'd0, DDIV});
      read_check("txdata_reads_zero", BASE, 32'h0);
      read_check("out_of_map_read", BASE + 32'hC, 32'h0);
      read_addr = BASE + 32'h4;
      read_enable = 1'b0;
      #1;
      check("read_disabled", read_data, 32'h0);

      // 2. single frame 0x55 at div 4, with latency and status timing
      set_div(4);
      push(8'h55, 4);
      check("tx_high_at_push_edge", {31'd0, tx}, 32'd1);
      read_check("status_after_push", BASE + 32'h4, 32'h0);
      tick(1);
      check("tx_low_after_pop", {31'd0, tx}, 32'd0);
      read_check("status_after_pop", BASE + 32'h4, 32'h6);
      wait_drain("drain_55", 200);
      read_check("status_idle_55", BASE + 32'h4, 32'h2);

      // 3. back-to-back frames
      base_idx = start_cyc.size();
      push(8'hA5, 4);
      push(8'h3C, 4);
      wait_drain("drain_b2b", 300);
      check("b2b_spacing", 32'(start_cyc[base_idx+1] - start_cyc[base_idx]), 32'd40);

      // 4. overflow: 10 pushes, 9 accepted
      f0 = frames_seen;
      for (int i = 0; i < 10; i++) begin
         logic [7:0] b;
         b = 8'($urandom());
         if (i < 9) push(b, 4);
         else bus_write(BASE, {24'd0, b}, 4'b0001);
      end
      read_check("status_full_ovf", BASE + 32'h4, 32'hD);
      bus_write(BASE + 32'h4, 32'h8, 4'b0001);
      read_check("status_ovf_cleared", BASE + 32'h4, 32'h5);
      wait_drain("drain_ovf", 2000);
      check("ovf_frame_count", 32'(frames_seen - f0), 32'd9);
      read_check("status_after_ovf", BASE + 32'h4, 32'h2);

      // 5. BAUDDIV=0 acts as 1; mid-frame BAUDDIV write applies next frame
      base_idx = start_cyc.size();
      set_div(0);
      push(8'hFF, 1);
      push(8'h81, 2);
      tick(3);
      set_div(2);
      wait_drain("drain_div", 200);
      check("div0_frame_len", 32'(start_cyc[base_idx+1] - start_cyc[base_idx]), 32'd10);
      read_check("bauddiv_readback", BASE + 32'h8, 32'h2);
      bus_write(BASE + 32'h8, 32'hABCD_12EE, 4'b0010);
      read_check("bauddiv_byte1_only", BASE + 32'h8, 32'h1202);
      bus_write(BASE + 32'hC, 32'h0000_0055, 4'b1111);
      bus_write(BASE - 32'h4, 32'h0000_0033, 4'b1111);
      read_check("bauddiv_untouched", BASE + 32'h8, 32'h1202);

      // randomized rounds, never more than DEPTH pushes per round
      for (int r = 0; r < 6; r++) begin
         int n;
         int exp_frames;
         set_div($urandom_range(0, 6));
         f0 = frames_seen;
         exp_frames = 0;
         n = $urandom_range(1, DEPTH);
         for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            tick($urandom_range(0, 2));
            b = 8'($urandom());
            if ($urandom_range(0, 3) == 0) begin
               bus_write(BASE, {24'd0, b}, 4'b1110);
            end else begin
               push(b, eff(model_div));
               exp_frames++;
            end
         end
         wait_drain("drain_random", 1000);
         check("random_frame_count", 32'(frames_seen - f0), 32'(exp_frames));
         read_check("random_status", BASE + 32'h4, 32'h2);
      end

      // 6. reset during DATA bit 3 aborts and discards queue
      set_div(4);
      push(8'h0F, 4);
      push(8'hF0, 4);
      push(8'h5A, 4);
      tick(15);
      reset = 1'b1;
      sb_q.delete();
      f0 = frames_seen;
      tick(1);
      check("reset_abort_tx", {31'd0, tx}, 32'd1);
      read_check("reset_abort_status", BASE + 32'h4, 32'h2);
      reset = 1'b0;
      tick(150);
      check("no_frames_after_reset", 32'(frames_seen - f0), 32'd0);
      check("tx_idle_after_reset", {31'd0, tx}, 32'd1);
      read_check("status_after_reset", BASE + 32'h4, 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
